// File: rtl/vec_stream_gen.sv
// Burst generator that emits vector words of constant, ramp or LFSR data into a FIFO with gaps and back-pressure.
// Define VEC_STREAM_GEN_LFSR_EN to build the per-lane LFSR pattern for mode 2; otherwise mode 2 is constant.
module vec_stream_gen #(
   parameter int WIDTH_VECTOR = 16,
   parameter int N            = 16,
   parameter int CNT_W        = 16,
   parameter int GAP_W        = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             stop,
   input  logic [1:0]                       mode,
   input  logic [N-1:0]                     seed,
   input  logic [N-1:0]                     step,
   input  logic [CNT_W-1:0]                 burst_len,
   input  logic [GAP_W-1:0]                 gap,
   input  logic                             fifo_full,
   output logic [WIDTH_VECTOR-1:0][N-1:0]   fifo_wdata,
   output logic                             fifo_winc,
   output logic                             busy,
   output logic                             done,
   output logic [CNT_W-1:0]                 words_sent
);

   localparam int LANE_SH = $clog2(WIDTH_VECTOR);
`ifdef VEC_STREAM_GEN_LFSR_EN
   localparam logic [N-1:0] LFSR_TAPS = N'(16'hB400);
`endif

   typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

   state_t                           r_state;
   state_t                           w_state_next;
   logic [1:0]                       r_mode;
   logic [N-1:0]                     r_step;
   logic [CNT_W-1:0]                 r_burst_len;
   logic [GAP_W-1:0]                 r_gap;
   logic [GAP_W-1:0]                 r_gap_cnt;
   logic [CNT_W-1:0]                 r_words_sent;
   logic [WIDTH_VECTOR-1:0][N-1:0]   r_wdata;
   logic [N-1:0]                     w_init [WIDTH_VECTOR];
   logic [N-1:0]                     w_next [WIDTH_VECTOR];
   logic                             w_last;

   assign w_last     = (r_words_sent + CNT_W'(1)) == r_burst_len;
   assign fifo_winc  = (r_state == RUN) && !fifo_full && !stop && !rst;
   assign busy       = (r_state != IDLE) && !rst;
   assign done       = (r_state == DONE) && !rst;
   assign fifo_wdata = r_wdata;
   assign words_sent = r_words_sent;

   // Per lane: first word from the live inputs at start, successor word from the held word.
   generate
      for (genvar gi = 0; gi < WIDTH_VECTOR; gi++) begin : g_lane
         logic [N-1:0] w_ramp_init;
         logic [N-1:0] w_ramp_next;
         assign w_ramp_init = seed + N'(gi) * step;
         assign w_ramp_next = r_wdata[gi] + (r_step << LANE_SH);
`ifdef VEC_STREAM_GEN_LFSR_EN
         logic [N-1:0] w_lfsr_seed;
         logic [N-1:0] w_lfsr_init;
         logic [N-1:0] w_lfsr_next;
         assign w_lfsr_seed = seed ^ N'(gi);
         assign w_lfsr_init = (w_lfsr_seed == '0) ? N'(1) : w_lfsr_seed;
         assign w_lfsr_next = {1'b0, r_wdata[gi][N-1:1]} ^ (r_wdata[gi][0] ? LFSR_TAPS : '0);
         assign w_init[gi]  = (mode == 2'd1) ? w_ramp_init :
                              (mode == 2'd2) ? w_lfsr_init : seed;
         assign w_next[gi]  = (r_mode == 2'd1) ? w_ramp_next :
                              (r_mode == 2'd2) ? w_lfsr_next : r_wdata[gi];
`else
         assign w_init[gi]  = (mode == 2'd1) ? w_ramp_init : seed;
         assign w_next[gi]  = (r_mode == 2'd1) ? w_ramp_next : r_wdata[gi];
`endif
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (start) w_state_next = (burst_len == '0) ? DONE : RUN;
         end
         RUN: begin
            if (stop)                w_state_next = IDLE;
            else if (!fifo_full) begin
               if (w_last)           w_state_next = DONE;
               else if (r_gap != '0) w_state_next = GAP;
               else                  w_state_next = RUN;
            end
         end
         GAP: begin
            if (stop)                  w_state_next = IDLE;
            else if (r_gap_cnt == '0)  w_state_next = RUN;
         end
         DONE: w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode       <= '0;
         r_step       <= '0;
         r_burst_len  <= '0;
         r_gap        <= '0;
         r_gap_cnt    <= '0;
         r_words_sent <= '0;
         r_wdata      <= '0;
      end else begin
         if (r_state == IDLE && start) begin
            r_mode       <= mode;
            r_step       <= step;
            r_burst_len  <= burst_len;
            r_gap        <= gap;
            r_words_sent <= '0;
            for (int i = 0; i < WIDTH_VECTOR; i++) r_wdata[i] <= w_init[i];
         end
         if (fifo_winc) begin
            r_words_sent <= r_words_sent + CNT_W'(1);
            for (int i = 0; i < WIDTH_VECTOR; i++) r_wdata[i] <= w_next[i];
         end
         // The counter holds the remaining idle cycles after the current one.
         if (r_state == RUN && w_state_next == GAP)
            r_gap_cnt <= r_gap - GAP_W'(1);
         else if (r_state == GAP && r_gap_cnt != '0)
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
   end

endmodule

// File: tb/tb_vec_stream_gen.sv
// Directed bench for vec_stream_gen: table of bursts plus hand sequences for back-pressure, stop, reset and empty bursts.
module tb_vec_stream_gen;

   logic                 clk = 1'b0;
   logic                 rst, start, stop, fifo_full;
   logic [1:0]           mode;
   logic [15:0]          seed, step, burst_len;
   logic [7:0]           gap;
   logic [15:0][15:0]    fifo_wdata;
   logic                 fifo_winc, busy, done;
   logic [15:0]          words_sent;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vec_stream_gen dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .seed(seed), .step(step), .burst_len(burst_len), .gap(gap),
      .fifo_full(fifo_full), .fifo_wdata(fifo_wdata), .fifo_winc(fifo_winc),
      .busy(busy), .done(done), .words_sent(words_sent)
   );

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] seed;
      logic [15:0] step;
      logic [15:0] len;
      logic [7:0]  gap;
      int          spacing;
      logic [15:0] f0, f15, l0, l15;
   } vec_t;

   vec_t tv [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [1:0] m, input logic [15:0] s, input logic [15:0] st,
                         input logic [15:0] len, input logic [7:0] g);
      mode = m; seed = s; step = st; burst_len = len; gap = g; start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      logic [15:0][15:0] w_first, w_last;
      int nwr, prev_t, done_cnt, done_t, gap_bad;
      logic finished;

      tv[0] = '{2'd1, 16'h0000, 16'h0001, 16'd3, 8'd0, 1, 16'h0000, 16'h000F, 16'h0020, 16'h002F};
      tv[1] = '{2'd0, 16'hA5A5, 16'h0000, 16'd4, 8'd2, 3, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
      tv[2] = '{2'd1, 16'hFFF0, 16'h0001, 16'd2, 8'd0, 1, 16'hFFF0, 16'hFFFF, 16'h0000, 16'h000F};
      tv[3] = '{2'd3, 16'h1234, 16'h0007, 16'd2, 8'd1, 2, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
`ifdef VEC_STREAM_GEN_LFSR_EN
      tv[4] = '{2'd2, 16'hBEEF, 16'h0000, 16'd2, 8'd0, 1, 16'hBEEF, 16'hBEE0, 16'hEB77, 16'h5F70};
`else
      tv[4] = '{2'd2, 16'hBEEF, 16'h0000, 16'd2, 8'd0, 1, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
`endif
      tv[5] = '{2'd1, 16'h0100, 16'h0003, 16'd1, 8'd5, 1, 16'h0100, 16'h012D, 16'h0100, 16'h012D};
      tv[6] = '{2'd1, 16'h1000, 16'h0010, 16'd3, 8'd1, 2, 16'h1000, 16'h10F0, 16'h1200, 16'h12F0};

      rst = 1'b1; start = 1'b1; stop = 1'b0; fifo_full = 1'b0;
      mode = 2'd1; seed = 16'h1111; step = 16'h1; burst_len = 16'd5; gap = 8'd0;
      cyc(); cyc();
      chk("rst_wdata_nz", 64'(fifo_wdata != '0), 0);
      chk("rst_words", 64'(words_sent), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_winc", 64'(fifo_winc), 0);
      rst = 1'b0; start = 1'b0;
      cyc();

      for (int t = 0; t < 7; t++) begin
         launch(tv[t].mode, tv[t].seed, tv[t].step, tv[t].len, tv[t].gap);
         nwr = 0; prev_t = 0; done_cnt = 0; done_t = -1; gap_bad = 0; finished = 1'b0;
         w_first = '0; w_last = '0;
         for (int c = 0; c < 200; c++) begin
            if (fifo_winc) begin
               if (nwr == 0) w_first = fifo_wdata;
               else if (c - prev_t != tv[t].spacing) gap_bad++;
               w_last = fifo_wdata;
               prev_t = c;
               nwr++;
            end
            if (done) begin done_cnt++; done_t = c; end
            if (!busy) begin finished = 1'b1; break; end
            cyc();
         end
         $display("burst %0d mode=%0d len=%0d gap=%0d writes=%0d words_sent=%0d",
                  t, tv[t].mode, tv[t].len, tv[t].gap, nwr, words_sent);
         chk($sformatf("t%0d_finished", t), 64'(finished), 1);
         chk($sformatf("t%0d_writes", t), 64'(nwr), 64'(tv[t].len));
         chk($sformatf("t%0d_first_l0", t), 64'(w_first[0]), 64'(tv[t].f0));
         chk($sformatf("t%0d_first_l15", t), 64'(w_first[15]), 64'(tv[t].f15));
         chk($sformatf("t%0d_last_l0", t), 64'(w_last[0]), 64'(tv[t].l0));
         chk($sformatf("t%0d_last_l15", t), 64'(w_last[15]), 64'(tv[t].l15));
         chk($sformatf("t%0d_spacing_bad", t), 64'(gap_bad), 0);
         chk($sformatf("t%0d_done_cnt", t), 64'(done_cnt), 1);
         chk($sformatf("t%0d_done_time", t), 64'(done_t), 64'(prev_t + 1));
         chk($sformatf("t%0d_words_sent", t), 64'(words_sent), 64'(tv[t].len));
      end

      // Back-pressure: word 1 must wait and stay stable while full is high.
      launch(2'd1, 16'h0000, 16'h0001, 16'd2, 8'd0);
      chk("bp_first_winc", 64'(fifo_winc), 1);
      cyc();
      fifo_full = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp_full%0d_winc", k), 64'(fifo_winc), 0);
         chk($sformatf("bp_full%0d_l0", k), 64'(fifo_wdata[0]), 16);
         chk($sformatf("bp_full%0d_l15", k), 64'(fifo_wdata[15]), 31);
         cyc();
      end
      fifo_full = 1'b0;
      #1;
      chk("bp_release_winc", 64'(fifo_winc), 1);
      chk("bp_release_l0", 64'(fifo_wdata[0]), 16);
      cyc();
      chk("bp_done", 64'(done), 1);
      chk("bp_words", 64'(words_sent), 2);
      cyc();
      $display("backpressure burst words_sent=%0d busy=%0d", words_sent, busy);
      chk("bp_idle", 64'(busy), 0);

      // Stop after the 10th write; a start pulse mid-burst must be ignored.
      launch(2'd0, 16'h0005, 16'h0000, 16'd100, 8'd0);
      for (int w = 0; w < 10; w++) begin
         chk($sformatf("stop_w%0d_winc", w), 64'(fifo_winc), 1);
         if (w == 5) begin start = 1'b1; burst_len = 16'd7; end
         cyc();
         start = 1'b0; burst_len = 16'd100;
      end
      stop = 1'b1;
      #1;
      chk("stop_cycle_winc", 64'(fifo_winc), 0);
      cyc();
      stop = 1'b0;
      #1;
      $display("stop burst words_sent=%0d busy=%0d done=%0d", words_sent, busy, done);
      chk("stop_busy", 64'(busy), 0);
      chk("stop_done", 64'(done), 0);
      chk("stop_words", 64'(words_sent), 10);
      cyc();
      chk("stop_done_later", 64'(done), 0);
      chk("stop_words_hold", 64'(words_sent), 10);

      // Stop while in a gap.
      launch(2'd0, 16'h0007, 16'h0000, 16'd5, 8'd3);
      chk("gstop_winc", 64'(fifo_winc), 1);
      cyc();
      stop = 1'b1;
      #1;
      chk("gstop_gap_winc", 64'(fifo_winc), 0);
      cyc();
      stop = 1'b0;
      #1;
      $display("gap-stop burst words_sent=%0d busy=%0d", words_sent, busy);
      chk("gstop_busy", 64'(busy), 0);
      chk("gstop_words", 64'(words_sent), 1);
      chk("gstop_done", 64'(done), 0);

      // Empty burst: one-cycle done, no writes, counter cleared.
      launch(2'd1, 16'h0000, 16'h0001, 16'd0, 8'd0);
      $display("empty burst done=%0d winc=%0d words_sent=%0d", done, fifo_winc, words_sent);
      chk("empty_done", 64'(done), 1);
      chk("empty_winc", 64'(fifo_winc), 0);
      chk("empty_words", 64'(words_sent), 0);
      cyc();
      chk("empty_done_off", 64'(done), 0);
      chk("empty_busy_off", 64'(busy), 0);

      // Reset mid-burst.
      launch(2'd1, 16'h1111, 16'h0001, 16'd50, 8'd0);
      cyc(); cyc(); cyc();
      rst = 1'b1;
      #1;
      chk("mrst_cycle_winc", 64'(fifo_winc), 0);
      cyc();
      rst = 1'b0;
      #1;
      $display("reset burst busy=%0d words_sent=%0d", busy, words_sent);
      chk("mrst_wdata_nz", 64'(fifo_wdata != '0), 0);
      chk("mrst_words", 64'(words_sent), 0);
      chk("mrst_busy", 64'(busy), 0);
      chk("mrst_done", 64'(done), 0);
      chk("mrst_winc", 64'(fifo_winc), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
